// File: rtl/deser8_pkg.sv
// Shared types and sizes for the deser8 serial-to-parallel receiver.
// Optional parity frame bit is enabled by defining DESER8_PARITY_EN.
package deser8_pkg;
  localparam int FRAME_BITS = 8;
  localparam int SLOT_W     = 3;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECV   = 2'd1,
    PARITY = 2'd2
  } state_t;
endpackage

// File: rtl/dec3to8.sv
// One-hot decoder turning the write position into per-bit byte write enables.
module dec3to8
  import deser8_pkg::*;
(
  input  logic [SLOT_W-1:0]     i_sel,
  input  logic                  i_en,
  output logic [FRAME_BITS-1:0] o_onehot
);
  always_comb begin
    o_onehot = '0;
    if (i_en) o_onehot[i_sel] = 1'b1;
  end
endmodule

// File: rtl/deser8.sv
// Serial-to-parallel byte receiver with a valid/ready output and overrun pulse.
// Define DESER8_PARITY_EN to expect an even-parity 9th bit after each frame.
module deser8
  import deser8_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  in_bit,
  input  logic                  start,
  output logic [FRAME_BITS-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SLOT_W-1:0]     slot,
  output logic                  busy,
  output logic                  overrun,
  output logic                  parity_err
);
  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [SLOT_W-1:0]       r_slot;
  logic [SLOT_W-1:0]       w_slot_nxt;
  logic [FRAME_BITS-1:0]   r_frame;
  logic [FRAME_BITS-1:0]   r_out_data;
  logic                    r_out_valid;
  logic                    r_overrun;
  logic                    r_parity_err;

  logic                    w_restart;
  logic                    w_data_bit;
  logic [SLOT_W-1:0]       w_wr_slot;
  logic [SLOT_W-1:0]       w_wr_pos;
  logic [FRAME_BITS-1:0]   w_wr_en;
  logic [FRAME_BITS-1:0]   w_frame_base;
  logic [FRAME_BITS-1:0]   w_frame_wr;
  logic                    w_done;
  logic                    w_load;
  logic                    w_drop;
  logic                    w_perr;

  // A start bit always lands in slot 0 and wipes any partial frame.
  assign w_restart    = in_valid & start;
  assign w_data_bit   = in_valid & (start | (r_state == RECV));
  assign w_wr_slot    = w_restart ? '0 : r_slot;
  assign w_wr_pos     = MSB_FIRST ? (LAST_SLOT - w_wr_slot) : w_wr_slot;
  assign w_frame_base = w_restart ? '0 : r_frame;
  assign w_frame_wr   = (w_frame_base & ~w_wr_en) | (w_wr_en & {FRAME_BITS{in_bit}});

  dec3to8 u_dec (
    .i_sel    (w_wr_pos),
    .i_en     (w_data_bit),
    .o_onehot (w_wr_en)
  );

`ifdef DESER8_PARITY_EN
  assign w_perr = ^{w_frame_wr, in_bit};
`else
  assign w_perr = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_slot_nxt  = r_slot;
    w_done      = 1'b0;
    if (w_restart) begin
      w_state_nxt = RECV;
      w_slot_nxt  = SLOT_W'(1);
    end else if (in_valid) begin
      case (r_state)
        RECV: begin
          if (r_slot == LAST_SLOT) begin
`ifdef DESER8_PARITY_EN
            // slot stays at 7 until the parity bit closes the frame
            w_state_nxt = PARITY;
`else
            w_state_nxt = IDLE;
            w_slot_nxt  = '0;
            w_done      = 1'b1;
`endif
          end else begin
            w_slot_nxt = r_slot + SLOT_W'(1);
          end
        end
`ifdef DESER8_PARITY_EN
        PARITY: begin
          w_state_nxt = IDLE;
          w_slot_nxt  = '0;
          w_done      = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign w_load = w_done & (~r_out_valid | out_ready);
  assign w_drop = w_done & r_out_valid & ~out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_slot       <= '0;
      r_frame      <= '0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_overrun    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_slot    <= w_slot_nxt;
      r_frame   <= w_frame_wr;
      r_overrun <= w_drop;
      if (w_load) begin
        r_out_data   <= w_frame_wr;
        r_out_valid  <= 1'b1;
        r_parity_err <= w_perr;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign slot       = r_slot;
  assign busy       = (r_state != IDLE);
  assign overrun    = r_overrun;
  assign parity_err = r_parity_err;
endmodule
